axi_pwm_generator_mc: RTL and testbench

Multi-channel successor to the single-instance AXI PWM generator. It is an AXI4-Lite slave that drives NUM_CH PWM outputs from one shared period counter. Each channel has its own duty, enable and polarity. Period and duty writes are double-buffered and take effect together at the next period boundary, so outputs never glitch. It sits in the PL behind the PS M_AXI_GP interconnect, with pwm_o routed to Pmod/LED pins.

---
 rtl/pwm_gen_pkg.sv | 39 +++
 rtl/pwm_gen_core.sv | 62 ++++++
 rtl/axi_pwm_generator_mc.sv | 182 ++++++++++++++++++
 tb/tb_axi_pwm_generator_mc.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared definitions for the multi-channel AXI PWM generator.
// Register byte offsets, register bit positions, the AXI response encoding
// and a byte-strobe merge helper used by the register file.
package pwm_gen_pkg;

  localparam logic [31:0] CTRL_OFF     = 32'h00;
  localparam logic [31:0] PERIOD_OFF   = 32'h04;
  localparam logic [31:0] CH_EN_OFF    = 32'h08;
  localparam logic [31:0] POL_OFF      = 32'h0C;
  localparam logic [31:0] STATUS_OFF   = 32'h10;
  localparam logic [31:0] IRQ_MASK_OFF = 32'h14;
  localparam logic [31:0] DUTY_BASE    = 32'h20;

  localparam int unsigned GEN_EN_BIT   = 0;
  localparam int unsigned UPDATE_BIT   = 1;
  localparam int unsigned UPD_PEND_BIT = 0;
  localparam int unsigned WRAP_BIT     = 1;
  localparam int unsigned IRQ_MASK_BIT = 0;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  // Replace only the bytes of old whose write strobe is set.
  function automatic logic [31:0] merge_strb(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_gen_core.sv
// PWM engine: shared period counter, active (double-buffered) period/duty
// copies, per-channel compare and registered outputs.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   gen_en            generator enable; counter held at 0 while low
//   ch_en, pol        per-channel enable / active-low select (immediate)
//   upd_pend          software update request pending
//   period_s, duty_s  software (shadow) period and duties
//   pwm               registered PWM outputs
//   wrap              high in the cycle the counter wraps
//   load              high in the cycle the active copies are reloaded
module pwm_gen_core #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           gen_en,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH-1:0]              pol,
  input  logic                           upd_pend,
  input  logic [CNT_W-1:0]               period_s,
  input  logic [NUM_CH-1:0][CNT_W-1:0]   duty_s,
  output logic [NUM_CH-1:0]              pwm,
  output logic                           wrap,
  output logic                           load
);

  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             period_a;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_a;
  logic [NUM_CH-1:0]            raw;

  assign wrap = gen_en & (cnt == period_a);
  // While stopped the active copies track software continuously.
  assign load = ~gen_en | (wrap & upd_pend);

  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      raw[k] = gen_en & ch_en[k] & (cnt < duty_a[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      period_a <= '0;
      duty_a   <= '0;
      pwm      <= '0;
    end else begin
      if (!gen_en || wrap) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
      if (load) begin
        period_a <= period_s;
        duty_a   <= duty_s;
      end
      pwm <= raw ^ pol;
    end
  end

endmodule

// File: rtl/axi_pwm_generator_mc.sv
// AXI4-Lite register file for the multi-channel PWM generator.
// Ports: s00_axi_* standard AXI4-Lite slave (always OKAY responses),
//        pwm_o (NUM_CH PWM outputs), period_tick_o (counter wrap pulse),
//        irq_o (level interrupt, only when PWM_GEN_IRQ_EN is defined).
// Build option: define PWM_GEN_IRQ_EN to add IRQ_MASK at 0x14 and irq_o.
module axi_pwm_generator_mc
  import pwm_gen_pkg::*;
#(
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned CNT_W              = 16,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_CH-1:0]               pwm_o,
  output logic                            period_tick_o
`ifdef PWM_GEN_IRQ_EN
  ,
  output logic                            irq_o
`endif
);

  logic                         gen_en;
  logic [CNT_W-1:0]             period_s;
  logic [NUM_CH-1:0]            ch_en;
  logic [NUM_CH-1:0]            pol;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_s;
  logic                         upd_pend;
  logic                         wrap_flag;
  logic                         wrap;
  logic                         load;
  logic                         wr_hs;
  logic                         rd_hs;
  logic [31:0]                  wa;
  logic [31:0]                  ra;
  logic [31:0]                  rd_word;
  logic                         upd_req;
  logic                         wrap_clr;
`ifdef PWM_GEN_IRQ_EN
  logic                         irq_mask;
`endif
  logic                         unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot};

  assign wr_hs           = s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
  assign rd_hs           = s00_axi_arvalid & ~s00_axi_rvalid;
  assign s00_axi_awready = wr_hs;
  assign s00_axi_wready  = wr_hs;
  assign s00_axi_arready = rd_hs;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_rresp   = RESP_OKAY;

  assign wa = 32'(s00_axi_awaddr) & ~32'h3;
  assign ra = 32'(s00_axi_araddr) & ~32'h3;

  assign upd_req  = wr_hs & (wa == CTRL_OFF) & s00_axi_wstrb[0] & s00_axi_wdata[UPDATE_BIT];
  assign wrap_clr = wr_hs & (wa == STATUS_OFF) & s00_axi_wstrb[0] & s00_axi_wdata[WRAP_BIT];

  always_comb begin
    rd_word = '0;
    case (ra)
      CTRL_OFF:   rd_word[GEN_EN_BIT] = gen_en;
      PERIOD_OFF: rd_word[CNT_W-1:0] = period_s;
      CH_EN_OFF:  rd_word[NUM_CH-1:0] = ch_en;
      POL_OFF:    rd_word[NUM_CH-1:0] = pol;
      STATUS_OFF: begin
        rd_word[UPD_PEND_BIT] = upd_pend;
        rd_word[WRAP_BIT]     = wrap_flag;
      end
`ifdef PWM_GEN_IRQ_EN
      IRQ_MASK_OFF: rd_word[IRQ_MASK_BIT] = irq_mask;
`else
      IRQ_MASK_OFF: rd_word = '0;
`endif
      default: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (ra == DUTY_BASE + 32'(4*k)) rd_word[CNT_W-1:0] = duty_s[k];
        end
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      gen_en         <= 1'b0;
      period_s       <= '0;
      ch_en          <= '0;
      pol            <= '0;
      duty_s         <= '0;
      upd_pend       <= 1'b0;
      wrap_flag      <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
`ifdef PWM_GEN_IRQ_EN
      irq_mask       <= 1'b0;
      irq_o          <= 1'b0;
`endif
    end else begin
      if (wr_hs)               s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;

      if (rd_hs) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end

      // A request in the reload cycle wins so it is honoured at the next wrap.
      if (upd_req)   upd_pend <= 1'b1;
      else if (load) upd_pend <= 1'b0;

      // A fresh wrap wins over a simultaneous clear.
      if (wrap)          wrap_flag <= 1'b1;
      else if (wrap_clr) wrap_flag <= 1'b0;

`ifdef PWM_GEN_IRQ_EN
      irq_o <= wrap_flag & irq_mask;
`endif

      if (wr_hs) begin
        case (wa)
          CTRL_OFF: if (s00_axi_wstrb[0]) gen_en <= s00_axi_wdata[GEN_EN_BIT];
          PERIOD_OFF: period_s <= CNT_W'(merge_strb(32'(period_s), s00_axi_wdata, s00_axi_wstrb));
          CH_EN_OFF:  ch_en <= NUM_CH'(merge_strb(32'(ch_en), s00_axi_wdata, s00_axi_wstrb));
          POL_OFF:    pol <= NUM_CH'(merge_strb(32'(pol), s00_axi_wdata, s00_axi_wstrb));
`ifdef PWM_GEN_IRQ_EN
          IRQ_MASK_OFF: if (s00_axi_wstrb[0]) irq_mask <= s00_axi_wdata[IRQ_MASK_BIT];
`endif
          default: begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (wa == DUTY_BASE + 32'(4*k))
                duty_s[k] <= CNT_W'(merge_strb(32'(duty_s[k]), s00_axi_wdata, s00_axi_wstrb));
            end
          end
        endcase
      end
    end
  end

  pwm_gen_core #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_core (
    .clk      (s00_axi_aclk),
    .rst_n    (s00_axi_aresetn),
    .gen_en   (gen_en),
    .ch_en    (ch_en),
    .pol      (pol),
    .upd_pend (upd_pend),
    .period_s (period_s),
    .duty_s   (duty_s),
    .pwm      (pwm_o),
    .wrap     (wrap),
    .load     (load)
  );

  assign period_tick_o = wrap;

endmodule

// File: tb/tb_axi_pwm_generator_mc.sv
// Self-checking bench for axi_pwm_generator_mc: directed scenarios followed by
// random register traffic, compared against a behavioural model of the
// register map, double-buffered reload rules and PWM waveform.
module tb_axi_pwm_generator_mc;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned AW     = 7;
  localparam int unsigned PMASK  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              aresetn;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [NUM_CH-1:0] pwm_o;
  logic              period_tick_o;
`ifdef PWM_GEN_IRQ_EN
  logic              irq_o;
`endif

  axi_pwm_generator_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .pwm_o(pwm_o), .period_tick_o(period_tick_o)
`ifdef PWM_GEN_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                m_gen, m_pend, m_wrapf, m_bv, m_rv;
  int unsigned       m_cnt, m_period, m_period_a;
  int unsigned       m_duty [NUM_CH];
  int unsigned       m_duty_a [NUM_CH];
  logic [NUM_CH-1:0] m_chen, m_pol, m_pwm;
  logic [31:0]       m_rdata;
`ifdef PWM_GEN_IRQ_EN
  bit                m_irqmask, m_irq;
`endif
  int unsigned       waddr;
  logic              m_wrap_now, m_load, m_hs_w, m_hs_r, m_set_upd, m_clr_wrap;

  assign waddr      = 32'(awaddr);
  assign m_wrap_now = m_gen && (m_cnt == m_period_a);
  assign m_load     = !m_gen || (m_wrap_now && m_pend);
  assign m_hs_w     = awvalid && wvalid && !m_bv;
  assign m_hs_r     = arvalid && !m_rv;
  assign m_set_upd  = m_hs_w && waddr == 32'h00 && wstrb[0] && wdata[1];
  assign m_clr_wrap = m_hs_w && waddr == 32'h10 && wstrb[0] && wdata[1];

  function automatic int unsigned merge(input int unsigned old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int unsigned addr;
    logic [31:0] r;
    addr = 32'(a) & ~32'h3;
    r = '0;
    if (addr == 32'h00) r = {31'b0, m_gen};
    else if (addr == 32'h04) r = m_period;
    else if (addr == 32'h08) r = 32'(m_chen);
    else if (addr == 32'h0C) r = 32'(m_pol);
    else if (addr == 32'h10) r = {30'b0, m_wrapf, m_pend};
`ifdef PWM_GEN_IRQ_EN
    else if (addr == 32'h14) r = {31'b0, m_irqmask};
`endif
    else if (addr >= 32'h20 && (addr - 32'h20) / 4 < NUM_CH) r = m_duty[(addr - 32'h20) / 4];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!aresetn) begin
      m_gen <= 0; m_pend <= 0; m_wrapf <= 0; m_bv <= 0; m_rv <= 0;
      m_cnt <= 0; m_period <= 0; m_period_a <= 0;
      m_chen <= '0; m_pol <= '0; m_pwm <= '0; m_rdata <= '0;
      for (int k = 0; k < NUM_CH; k++) begin m_duty[k] <= 0; m_duty_a[k] <= 0; end
`ifdef PWM_GEN_IRQ_EN
      m_irqmask <= 0; m_irq <= 0;
`endif
    end else begin
      // Output shows whether the current phase lies inside the active duty.
      for (int k = 0; k < NUM_CH; k++)
        m_pwm[k] <= (m_gen && m_chen[k] && (m_cnt < m_duty_a[k])) ^ m_pol[k];
      m_cnt <= (!m_gen || m_wrap_now) ? 0 : m_cnt + 1;
      if (m_load) begin
        m_period_a <= m_period;
        for (int k = 0; k < NUM_CH; k++) m_duty_a[k] <= m_duty[k];
      end
      if (m_set_upd) m_pend <= 1; else if (m_load) m_pend <= 0;
      if (m_wrap_now) m_wrapf <= 1; else if (m_clr_wrap) m_wrapf <= 0;
`ifdef PWM_GEN_IRQ_EN
      m_irq <= m_wrapf && m_irqmask;
`endif
      if (m_hs_w) begin
        m_bv <= 1;
        if (waddr == 32'h00) begin
          if (wstrb[0]) m_gen <= wdata[0];
        end else if (waddr == 32'h04) m_period <= merge(m_period, wdata, wstrb) & PMASK;
        else if (waddr == 32'h08) m_chen <= NUM_CH'(merge(32'(m_chen), wdata, wstrb));
        else if (waddr == 32'h0C) m_pol <= NUM_CH'(merge(32'(m_pol), wdata, wstrb));
`ifdef PWM_GEN_IRQ_EN
        else if (waddr == 32'h14) begin
          if (wstrb[0]) m_irqmask <= wdata[0];
        end
`endif
        else for (int k = 0; k < NUM_CH; k++)
          if (waddr == 32'h20 + 4*k) m_duty[k] <= merge(m_duty[k], wdata, wstrb) & PMASK;
      end else if (bready) m_bv <= 0;
      if (m_hs_r) begin
        m_rv <= 1;
        m_rdata <= model_read(araddr);
      end else if (rready) m_rv <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pwm_o", 32'(pwm_o), 32'(m_pwm));
      check("period_tick_o", 32'(period_tick_o), 32'(m_wrap_now));
      check("bvalid", 32'(bvalid), 32'(m_bv));
      check("rvalid", 32'(rvalid), 32'(m_rv));
`ifdef PWM_GEN_IRQ_EN
      check("irq_o", 32'(irq_o), 32'(m_irq));
`endif
    end
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    check("awready", 32'(awready), 32'd1);
    check("wready", 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; bready = 1;
    #1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
    check("bvalid_seen", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    check("arready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 0; rready = 1;
    #1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
    check("rvalid_seen", 32'(rvalid), 32'd1);
    check("rdata_model", rdata, m_rdata);
    check("rresp", 32'(rresp), 32'd0);
    d = rdata;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!period_tick_o && n < 400);
    check("tick_seen", 32'(period_tick_o), 32'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    aresetn = 0;
    @(negedge clk);
    aresetn = 1;
  endtask

  logic [AW-1:0] addr_tbl [12] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h14,
                                   7'h18, 7'h20, 7'h24, 7'h28, 7'h2C, 7'h7C};

  initial begin
    logic [31:0] d;
    int hi, ticks;
    aresetn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_pwm", 32'(pwm_o), 32'd0);
    check("reset_tick", 32'(period_tick_o), 32'd0);
    aresetn = 1;

    // Basic waveform: period 10, duty 3
    axi_write(7'h04, 32'd9, 4'hF);
    axi_write(7'h20, 32'd3, 4'hF);
    axi_write(7'h08, 32'd1, 4'hF);
    axi_write(7'h00, 32'd1, 4'hF);
    axi_read(7'h00, d); check("rb_ctrl", d, 32'd1);
    axi_read(7'h04, d); check("rb_period", d, 32'd9);
    axi_read(7'h20, d); check("rb_duty0", d, 32'd3);
    axi_read(7'h08, d); check("rb_ch_en", d, 32'd1);
    wait_tick();
    hi = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); hi += int'(pwm_o[0]); end
    check("duty3_high_cycles", 32'(hi), 32'd3);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); ticks += int'(period_tick_o); end
    check("ticks_in_20", 32'(ticks), 32'd2);

    // Buffered duty update
    axi_write(7'h20, 32'd7, 4'hF);
    wait_tick();
    axi_write(7'h00, 32'd3, 4'hF);
    axi_read(7'h10, d); check("upd_pend_set", 32'(d[0]), 32'd1);
    wait_tick();
    axi_read(7'h10, d); check("status_after_wrap", d, 32'd2);
    hi = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); hi += int'(pwm_o[0]); end
    check("duty7_high_cycles", 32'(hi), 32'd7);

    // Duty 0 and duty above period, with inversion on channel 2
    axi_write(7'h24, 32'd0, 4'hF);
    axi_write(7'h28, 32'd12, 4'hF);
    axi_write(7'h0C, 32'h4, 4'hF);
    axi_write(7'h08, 32'h7, 4'hF);
    axi_write(7'h00, 32'd3, 4'hF);
    wait_tick();
    wait_tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("duty0_ch1", 32'(pwm_o[1]), 32'd0);
      check("dutybig_inv_ch2", 32'(pwm_o[2]), 32'd0);
    end

    // Byte strobes and unmapped read
    axi_write(7'h00, 32'd0, 4'hF);
    axi_write(7'h04, 32'd0, 4'hF);
    axi_write(7'h04, 32'hFFFF_FFFF, 4'b0001);
    axi_read(7'h04, d); check("strb_period", d, 32'h0000_00FF);
    axi_read(7'h7C, d); check("unmapped_read", d, 32'd0);

    // Reset in the middle of a running period
    axi_write(7'h00, 32'd1, 4'hF);
    repeat (37) @(negedge clk);
    reset_pulse();
    check("rst_pwm", 32'(pwm_o), 32'd0);
    check("rst_tick", 32'(period_tick_o), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      axi_read((i < 5) ? AW'(4*i) : AW'(32'h20 + 4*(i-5)), d);
      check("rst_reg_zero", d, 32'd0);
    end

`ifdef PWM_GEN_IRQ_EN
    axi_write(7'h14, 32'd1, 4'hF);
    axi_write(7'h04, 32'd4, 4'hF);
    axi_write(7'h00, 32'd1, 4'hF);
    wait_tick();
    repeat (2) @(negedge clk);
    check("irq_after_wrap", 32'(irq_o), 32'd1);
    axi_write(7'h10, 32'd2, 4'hF);
    wait_tick();
    repeat (2) @(negedge clk);
    check("irq_reassert", 32'(irq_o), 32'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 250; i++) begin
      int op;
      logic [AW-1:0] a;
      logic [3:0] s;
      op = $urandom_range(0, 19);
      a = addr_tbl[$urandom_range(0, 11)];
      s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      if (op < 10) axi_write(a, 32'($urandom_range(0, 20)), s);
      else if (op < 16) axi_read(a, d);
      else if (op < 19) repeat ($urandom_range(1, 15)) @(negedge clk);
      else reset_pulse();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
